kul4_err_sweep: RTL and testbench

Sequential error-characterisation engine for the team's 4x4 approximate multipliers. It sweeps every operand pair into a multiplier under test, samples the returned product after a configurable latency and compares it with the exact product. It accumulates error count, summed error distance and maximum error distance, which replaces the per-run simulation tally with synthesizable hardware. It sits on both sides of the multiplier: upstream as the operand source, downstream as the product consumer.

---
 rtl/kul4_err_sweep_if.sv | 12 +
 rtl/kul4_err_sweep.sv | 205 ++++++++++++++++++++
 tb/tb_kul4_err_sweep.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/kul4_err_sweep_if.sv
// Operand/product bus between the error sweep engine and a multiplier under test.
`timescale 1ns/1ps
interface kul4_err_sweep_if #(
    parameter int OP_W = 4
);
    logic [OP_W-1:0]   op_a;
    logic [OP_W-1:0]   op_b;
    logic [2*OP_W-1:0] prod_in;

    modport master (output op_a, output op_b, input prod_in);
    modport slave  (input op_a, input op_b, output prod_in);
endinterface

// File: rtl/kul4_err_sweep.sv
// Error-characterisation sweep for 4x4 approximate multipliers.
// Define KUL4_ERR_SWEEP_BIAS_EN to add the signed err_bias accumulator.
`timescale 1ns/1ps
module kul4_err_sweep #(
    parameter int OP_W    = 4,
    parameter int DUT_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    kul4_err_sweep_if.master         mul,
    output logic                     busy,
    output logic                     done,
    output logic [2*OP_W:0]          err_count,
    output logic [4*OP_W-1:0]        sum_ed,
    output logic [2*OP_W-1:0]        max_ed
`ifdef KUL4_ERR_SWEEP_BIAS_EN
    ,
    output logic signed [4*OP_W+1:0] err_bias
`endif
);
    localparam int PW = 2 * OP_W;
    localparam int TD = (DUT_LAT > 0) ? DUT_LAT : 1;
    localparam logic [PW-1:0] K_LAST = '1;
    localparam logic [2:0] DRAIN_INIT = 3'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic [PW-1:0]         k_q, k_d;
    logic [2:0]            drain_q, drain_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [PW:0]           err_q, err_d;
    logic [4*OP_W-1:0]     sum_q, sum_d;
    logic [PW-1:0]         max_q, max_d;
    logic [TD-1:0]         tv_q, tv_d;
    logic [TD-1:0][PW-1:0] tp_q, tp_d;
`ifdef KUL4_ERR_SWEEP_BIAS_EN
    logic signed [4*OP_W+1:0] bias_q, bias_d;
    logic signed [4*OP_W+1:0] sed;
`endif

    logic          iss_v;
    logic [PW-1:0] iss_p;
    logic          cmp_v;
    logic [PW-1:0] cmp_p;
    logic          ge;
    logic [PW-1:0] ed;

    assign mul.op_a = k_q[PW-1:OP_W];
    assign mul.op_b = k_q[OP_W-1:0];

    assign iss_v = (state_q == ISSUE);
    assign iss_p = {{OP_W{1'b0}}, k_q[PW-1:OP_W]}
                 * {{OP_W{1'b0}}, k_q[OP_W-1:0]};

    // Tag pipeline mirrors the multiplier latency so each product meets its reference.
    always_comb begin
        tv_d    = tv_q;
        tp_d    = tp_q;
        tv_d[0] = iss_v;
        tp_d[0] = iss_p;
        for (int i = 1; i < TD; i++) begin
            tv_d[i] = tv_q[i-1];
            tp_d[i] = tp_q[i-1];
        end
    end

    always_comb begin
        if (DUT_LAT == 0) begin
            cmp_v = iss_v;
            cmp_p = iss_p;
        end else begin
            cmp_v = tv_q[TD-1];
            cmp_p = tp_q[TD-1];
        end
    end

    assign ge = (mul.prod_in >= cmp_p);
    assign ed = ge ? (mul.prod_in - cmp_p) : (cmp_p - mul.prod_in);

`ifdef KUL4_ERR_SWEEP_BIAS_EN
    always_comb begin
        sed = $signed({{(PW+2){1'b0}}, ed});
        if (!ge) begin
            sed = -sed;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        drain_d = drain_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        sum_d   = sum_q;
        max_d   = max_q;
`ifdef KUL4_ERR_SWEEP_BIAS_EN
        bias_d  = bias_q;
`endif
        if (cmp_v) begin
            err_d = err_q + {{PW{1'b0}}, (ed != '0)};
            sum_d = sum_q + {{PW{1'b0}}, ed};
            if (ed > max_q) begin
                max_d = ed;
            end
`ifdef KUL4_ERR_SWEEP_BIAS_EN
            bias_d = bias_q + sed;
`endif
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    k_d     = '0;
                    busy_d  = 1'b1;
                    err_d   = '0;
                    sum_d   = '0;
                    max_d   = '0;
`ifdef KUL4_ERR_SWEEP_BIAS_EN
                    bias_d  = '0;
`endif
                end
            end
            ISSUE: begin
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    if (DUT_LAT == 0) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DRAIN;
                        drain_d = DRAIN_INIT;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            sum_q   <= '0;
            max_q   <= '0;
            tv_q    <= '0;
            tp_q    <= '0;
`ifdef KUL4_ERR_SWEEP_BIAS_EN
            bias_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            tv_q    <= tv_d;
            tp_q    <= tp_d;
`ifdef KUL4_ERR_SWEEP_BIAS_EN
            bias_q  <= bias_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err_count = err_q;
    assign sum_ed    = sum_q;
    assign max_ed    = max_q;
`ifdef KUL4_ERR_SWEEP_BIAS_EN
    assign err_bias  = bias_q;
`endif

endmodule

// File: tb/tb_kul4_err_sweep.sv
// Directed bench for kul4_err_sweep: latency 1 main instance plus latency 0 and 3.
`timescale 1ns/1ps
module tb_kul4_err_sweep;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic st1, st0, st3;
    int   mode;
    int   checks;
    int   failures;

    kul4_err_sweep_if #(.OP_W(4)) m1 ();
    kul4_err_sweep_if #(.OP_W(4)) m0 ();
    kul4_err_sweep_if #(.OP_W(4)) m3 ();

    logic       b1, d1, b0, d0, b3, d3;
    logic [8:0] e1, e0, e3;
    logic [15:0] s1, s0, s3;
    logic [7:0] x1, x0, x3;
`ifdef KUL4_ERR_SWEEP_BIAS_EN
    logic signed [17:0] g1, g0, g3;
`endif

    kul4_err_sweep #(.OP_W(4), .DUT_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .mul(m1.master),
        .busy(b1), .done(d1), .err_count(e1), .sum_ed(s1), .max_ed(x1)
`ifdef KUL4_ERR_SWEEP_BIAS_EN
        , .err_bias(g1)
`endif
    );
    kul4_err_sweep #(.OP_W(4), .DUT_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(st0), .mul(m0.master),
        .busy(b0), .done(d0), .err_count(e0), .sum_ed(s0), .max_ed(x0)
`ifdef KUL4_ERR_SWEEP_BIAS_EN
        , .err_bias(g0)
`endif
    );
    kul4_err_sweep #(.OP_W(4), .DUT_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(st3), .mul(m3.master),
        .busy(b3), .done(d3), .err_count(e3), .sum_ed(s3), .max_ed(x3)
`ifdef KUL4_ERR_SWEEP_BIAS_EN
        , .err_bias(g3)
`endif
    );

    // Multiplier models: 0 exact, 1 always zero, 2 exact xor 1
    function automatic logic [7:0] model(input int md, input logic [3:0] a,
                                         input logic [3:0] b);
        logic [7:0] p;
        p = 8'(a) * 8'(b);
        if (md == 1) p = 8'd0;
        else if (md == 2) p = p ^ 8'd1;
        return p;
    endfunction

    always @(posedge clk) m1.prod_in <= model(mode, m1.op_a, m1.op_b);
    assign m0.prod_in = 8'(m0.op_a) * 8'(m0.op_b);
    logic [7:0] p3a, p3b;
    always @(posedge clk) begin
        p3a <= 8'(m3.op_a) * 8'(m3.op_b);
        p3b <= p3a;
        m3.prod_in <= p3b;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) st0 = v;
        else if (sel == 3) st3 = v;
        else st1 = v;
    endtask

    function automatic logic get_done(input int sel);
        if (sel == 0) return d0;
        if (sel == 3) return d3;
        return d1;
    endfunction

    // Pulse start, then count edges after E0 until done is seen (-1 on timeout)
    task automatic run_sweep(input int sel, output int lat);
        lat = -1;
        @(posedge clk); #1;
        set_start(sel, 1'b1);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            if (sel == 1 && n == 90) begin
                chk("op_a_pair90", m1.op_a, 5);
                chk("op_b_pair90", m1.op_b, 10);
                chk("busy_mid", b1, 1);
            end
            if (get_done(sel)) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    typedef struct {
        int md;
        int err;
        int sum;
        int mx;
        int bias;
    } vec_t;

    vec_t vecs[3];
    int   lat;
    int   dcnt;
    int   first;

    initial begin
        checks = 0; failures = 0;
        mode = 0; st1 = 0; st0 = 0; st3 = 0;
        rst_n = 1'b0;
        vecs[0] = '{md: 0, err: 0,   sum: 0,     mx: 0,   bias: 0};
        vecs[1] = '{md: 1, err: 225, sum: 14400, mx: 225, bias: -14400};
        vecs[2] = '{md: 2, err: 256, sum: 256,   mx: 1,   bias: 128};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", b1, 0);
        chk("rst_done", d1, 0);
        chk("rst_err", e1, 0);
        chk("rst_sum", s1, 0);
        chk("rst_max", x1, 0);
        chk("rst_op_a", m1.op_a, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            mode = vecs[i].md;
            run_sweep(1, lat);
            chk($sformatf("v%0d_lat", i), lat, 257);
            chk($sformatf("v%0d_busy_at_done", i), b1, 0);
            chk($sformatf("v%0d_err", i), e1, vecs[i].err);
            chk($sformatf("v%0d_sum", i), s1, vecs[i].sum);
            chk($sformatf("v%0d_max", i), x1, vecs[i].mx);
`ifdef KUL4_ERR_SWEEP_BIAS_EN
            chk($sformatf("v%0d_bias", i), g1, vecs[i].bias);
`endif
            repeat (4) @(posedge clk);
            #1;
            chk($sformatf("v%0d_hold_err", i), e1, vecs[i].err);
            chk($sformatf("v%0d_hold_done", i), d1, 0);
        end

        // Reset in the middle of a sweep
        mode = 1;
        @(posedge clk); #1; st1 = 1;
        @(posedge clk); #1; st1 = 0;
        repeat (99) @(posedge clk);
        #1;
        chk("pre_rst_err_nonzero", (e1 != 0), 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", b1, 0);
        chk("mrst_err", e1, 0);
        chk("mrst_sum", s1, 0);
        chk("mrst_max", x1, 0);
        chk("mrst_op_a", m1.op_a, 0);
        chk("mrst_op_b", m1.op_b, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mode = 0;
        run_sweep(1, lat);
        chk("post_rst_lat", lat, 257);
        chk("post_rst_err", e1, 0);
        chk("post_rst_sum", s1, 0);

        // start re-pulsed mid-sweep and during drain is ignored
        mode = 2;
        dcnt = 0; first = -1;
        @(posedge clk); #1; st1 = 1;
        @(posedge clk); #1; st1 = 0;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            if (d1) begin
                dcnt++;
                if (first < 0) first = n;
            end
            st1 = (n == 49 || n == 255);
        end
        chk("reissue_done_count", dcnt, 1);
        chk("reissue_lat", first, 257);
        chk("reissue_err", e1, 256);
        chk("reissue_sum", s1, 256);

        // start held through DONE launches a new sweep on the first IDLE cycle
        @(posedge clk); #1; st1 = 1;
        @(posedge clk); #1;
        first = -1;
        for (int n = 1; n <= 700; n++) begin
            @(posedge clk); #1;
            if (n == 257) chk("hold_done", d1, 1);
            if (n == 258) chk("hold_idle_busy", b1, 0);
            if (n == 259) begin
                chk("hold_restart_busy", b1, 1);
                st1 = 0;
            end
            if (n > 259 && d1) begin
                first = n;
                break;
            end
        end
        chk("hold_second_lat", first, 516);
        chk("hold_second_err", e1, 256);

        // Latency 0 and 3 with exact models
        run_sweep(0, lat);
        chk("lat0_done", lat, 256);
        chk("lat0_err", e0, 0);
        chk("lat0_sum", s0, 0);
        chk("lat0_max", x0, 0);
        run_sweep(3, lat);
        chk("lat3_done", lat, 259);
        chk("lat3_err", e3, 0);
        chk("lat3_sum", s3, 0);
        chk("lat3_max", x3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
